// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC controller: state
// encoding, instruction field codes and one-hot control constants.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
        S_GETA, S_GETB, S_ALU, S_WRREG, S_CMP,
        S_MOVIMM, S_MOVR1, S_MOVR2, S_MOVR3,
        S_ADDR, S_LDAR, S_MEMRD, S_LDWB,
        S_STGB, S_STC, S_MEMWR, S_HALT, S_BR
    } state_t;

    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVR   = 2'b00;
    localparam logic [1:0] OP_MOVIMM = 2'b10;
    localparam logic [1:0] OP_CMP    = 2'b01;
    localparam logic [1:0] OP_MEM    = 2'b00;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

endpackage

// File: rtl/cpu_ctrl_waitcnt.sv
// Loadable down-counter used to stretch the memory states; zero_o tells the
// controller it may leave the current wait state.
module cpu_ctrl_waitcnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/cpu_controller_fsm.sv
// Moore controller for the 16-bit RISC datapath: fetch, ALU, MOV, LDR/STR, HALT.
// Define CPU_CTRL_BRANCH_EN to add the conditional branch state and pc_sel output.
module cpu_controller_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_LAT       = 1,
    parameter int CNT_W         = 4,
    parameter int HALT_ON_UNDEF = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] status,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
`ifdef CPU_CTRL_BRANCH_EN
    output logic       pc_sel,
`endif
    output logic       halted
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t state_q, state_d;
    logic   cnt_zero, cnt_load, cnt_dec;

`ifdef CPU_CTRL_BRANCH_EN
    logic br_taken;
    always_comb begin
        unique case (op)
            2'b00:   br_taken = 1'b1;
            2'b01:   br_taken = status[0];
            2'b10:   br_taken = ~status[0];
            default: br_taken = status[2] ^ status[1];
        endcase
    end
`else
    logic unused_status;
    assign unused_status = ^status;
`endif

    // The counter is reloaded only when a wait state is freshly entered, so a
    // held state keeps counting down.
    assign cnt_load = (state_d inside {S_IF1, S_MEMRD, S_MEMWR}) && (state_d != state_q);
    assign cnt_dec  = (state_q inside {S_IF1, S_MEMRD, S_MEMWR}) && !cnt_zero;

    cpu_ctrl_waitcnt #(.CNT_W(CNT_W)) u_waitcnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = S_RST;
        nsel      = NSEL_NONE;
        vsel      = VSEL_NONE;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MEM_NONE;
        halted    = 1'b0;
`ifdef CPU_CTRL_BRANCH_EN
        pc_sel    = 1'b0;
`endif
        case (state_q)
            S_RST:    begin reset_pc = 1'b1; load_pc = 1'b1; state_d = S_IF1; end
            S_IF1:    begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                state_d  = cnt_zero ? S_IF2 : S_IF1;
            end
            S_IF2:    begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; state_d = S_UPC; end
            S_UPC:    begin load_pc = 1'b1; state_d = S_DEC; end
            S_DEC:    begin
                state_d = (HALT_ON_UNDEF != 0) ? S_HALT : S_IF1;
                case (opcode)
                    OPC_MOV: begin
                        if (op == OP_MOVIMM)    state_d = S_MOVIMM;
                        else if (op == OP_MOVR) state_d = S_MOVR1;
                    end
                    OPC_ALU:          state_d = S_GETA;
                    OPC_LDR, OPC_STR: if (op == OP_MEM) state_d = S_GETA;
                    OPC_HALT:         state_d = S_HALT;
`ifdef CPU_CTRL_BRANCH_EN
                    OPC_BR:           state_d = S_BR;
`endif
                    default: ;
                endcase
            end
            S_MOVIMM: begin write = 1'b1; vsel = VSEL_IMM; nsel = NSEL_RN; state_d = S_IF1; end
            S_MOVR1:  begin nsel = NSEL_RM; loadb = 1'b1; state_d = S_MOVR2; end
            S_MOVR2:  begin asel = 1'b1; loadc = 1'b1; state_d = S_MOVR3; end
            S_MOVR3:  begin write = 1'b1; vsel = VSEL_C; nsel = NSEL_RD; state_d = S_IF1; end
            S_GETA:   begin
                nsel    = NSEL_RN;
                loada   = 1'b1;
                state_d = (opcode == OPC_ALU) ? S_GETB : S_ADDR;
            end
            S_GETB:   begin
                nsel    = NSEL_RM;
                loadb   = 1'b1;
                state_d = (op == OP_CMP) ? S_CMP : S_ALU;
            end
            S_ALU:    begin loadc = 1'b1; state_d = S_WRREG; end
            S_WRREG:  begin write = 1'b1; vsel = VSEL_C; nsel = NSEL_RD; state_d = S_IF1; end
            S_CMP:    begin loads = 1'b1; state_d = S_IF1; end
            S_ADDR:   begin bsel = 1'b1; loadc = 1'b1; state_d = S_LDAR; end
            S_LDAR:   begin
                load_addr = 1'b1;
                state_d   = (opcode == OPC_LDR) ? S_MEMRD : S_STGB;
            end
            S_MEMRD:  begin mem_cmd = MEM_READ; state_d = cnt_zero ? S_LDWB : S_MEMRD; end
            S_LDWB:   begin
                mem_cmd = MEM_READ;
                write   = 1'b1;
                vsel    = VSEL_MDATA;
                nsel    = NSEL_RD;
                state_d = S_IF1;
            end
            S_STGB:   begin nsel = NSEL_RD; loadb = 1'b1; state_d = S_STC; end
            S_STC:    begin asel = 1'b1; loadc = 1'b1; state_d = S_MEMWR; end
            S_MEMWR:  begin mem_cmd = MEM_WRITE; state_d = cnt_zero ? S_IF1 : S_MEMWR; end
            S_HALT:   begin halted = 1'b1; state_d = S_HALT; end
`ifdef CPU_CTRL_BRANCH_EN
            S_BR:     begin
                load_pc = br_taken;
                pc_sel  = br_taken;
                state_d = S_IF1;
            end
`endif
            default:  state_d = S_RST;
        endcase
    end

endmodule
